alu_stim_checker: RTL and testbench
===================================

ALU_STIM_CHECKER -- requirements
Module: alu_stim_checker

Interface
REQ-001 Parameter: LAT, 1, ALU result latency in clk cycles, legal range 1-4.
REQ-002 Parameter: CW, 16, width of pass/fail counters.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  pulse; begins a test run from IDLE or DONE.
REQ-006 Port: cmd_valid  input  1  stimulus vector present.
REQ-007 Port: cmd_ready  output  1  block accepts vector this cycle.
REQ-008 Port: cmd_a, cmd_b  input  32 each  operands.
REQ-009 Port: cmd_sel  input  4  ALU operation select.
REQ-010 Port: cmd_exp  input  32  expected ALU result.
REQ-011 Port: cmd_last  input  1  marks final vector of the run.
REQ-012 Port: alu_a, alu_b  output  32 each  operands to ALU.
REQ-013 Port: alu_sel  output  4  select to ALU.
REQ-014 Port: alu_out  input  32  ALU result, valid LAT cycles after operands are driven.
REQ-015 Port: busy  output  1  high in RUN or DRAIN.
REQ-016 Port: done  output  1  high in DONE.
REQ-017 Port: pass_cnt, fail_cnt  output  CW each  result counters.
REQ-018 Port: first_fail_idx  output  CW  index (0-based) of first mismatching vector; all-ones if none.
REQ-019 Port: first_fail_got  output  32  alu_out captured at first mismatch.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE shall exist; encoding is free.
REQ-021 IDLE/DONE + start -> RUN; counters, index and first-fail registers cleared in the same edge.
REQ-022 cmd_ready shall be 1 only in RUN; transfer occurs when cmd_valid && cmd_ready.
REQ-023 On transfer, alu_a/alu_b/alu_sel shall register cmd_a/cmd_b/cmd_sel at that edge and hold until next transfer.
REQ-024 Each transfer pushes {1, cmd_exp, vec_idx} into a LAT-deep shift pipeline; non-transfer cycles push a bubble (valid=0).
REQ-025 When the pipeline tail is valid, alu_out shall be compared to its expected value that cycle; match -> pass_cnt+1, mismatch -> fail_cnt+1.
REQ-026 pass_cnt and fail_cnt shall saturate at 2^CW-1, never wrap.
REQ-027 vec_idx increments per transfer and wraps modulo 2^CW.
REQ-028 First mismatch only shall load first_fail_idx and first_fail_got; later mismatches shall not overwrite.
REQ-029 Transfer with cmd_last=1 -> DRAIN; no further transfers accepted.
REQ-030 DRAIN -> DONE when pipeline contains no valid entries (exactly LAT cycles after last transfer).
REQ-031 DONE holds all results stable and done=1 until start.
REQ-032 start in RUN or DRAIN shall be ignored.
REQ-033 Throughput: one vector per cycle while cmd_valid stays high; no back-to-back stall.

Reset
REQ-034 rst=1 at a clock edge forces IDLE regardless of state, including mid-run.
REQ-035 Reset values: cmd_ready=0, busy=0, done=0, alu_a=alu_b=0, alu_sel=0, pass_cnt=fail_cnt=0, first_fail_idx=all-ones, first_fail_got=0, pipeline all invalid.
REQ-036 rst dominates start when both asserted.

Verification
REQ-037 LAT=1, 4 vectors all matching, last on 4th -> pass_cnt=4, fail_cnt=0, first_fail_idx=FFFF, done 1 cycle after last pipeline compare.
REQ-038 Vector 2 expected 0x00000002, ALU returns 0x00000003; vectors 0,1,3 match -> pass_cnt=3, fail_cnt=1, first_fail_idx=2, first_fail_got=0x00000003.
REQ-039 cmd_valid toggling 1,0,1,0 with LAT=3 -> only valid slots compared, counts equal transfers, DRAIN lasts exactly 3 cycles.
REQ-040 rst pulsed during RUN after 2 transfers -> next cycle all outputs at reset values, state IDLE, start required to resume.
REQ-041 CW=4, 20 matching vectors -> pass_cnt saturates at 15, vec_idx wraps.
REQ-042 start asserted in DONE -> counters cleared, busy=1, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/alu_stim_checker.sv
// rtl/alu_stim_checker.sv - ALU stimulus sequencer and result checker
//
// Feeds stimulus vectors to an external ALU, compares each result against the
// vector's expected value LAT cycles later and accumulates run statistics.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begins a run from IDLE or DONE (ignored otherwise)
//   cmd_valid/cmd_ready  vector handshake; cmd_ready only while running
//   cmd_a/cmd_b/cmd_sel  operands and operation select of the vector
//   cmd_exp              expected ALU result for the vector
//   cmd_last             marks the final vector of the run
//   alu_a/alu_b/alu_sel  registered operands driven to the ALU
//   alu_out              ALU result, sampled LAT cycles after operands change
//   busy, done           run in progress / results final and stable
//   pass_cnt, fail_cnt   saturating result counters
//   first_fail_idx       index of first mismatching vector, all-ones if none
//   first_fail_got       ALU result captured at the first mismatch
module alu_stim_checker #(
  parameter int LAT = 1,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_a,
  input  logic [31:0]   cmd_b,
  input  logic [3:0]    cmd_sel,
  input  logic [31:0]   cmd_exp,
  input  logic          cmd_last,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [3:0]    alu_sel,
  input  logic [31:0]   alu_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic [CW-1:0] first_fail_idx,
  output logic [31:0]   first_fail_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic xfer;
  logic clear;
  logic drain_empty;

  // Expectation pipeline: stage 0 is loaded on the transfer edge, the tail
  // lines up with the cycle in which alu_out carries that vector's result.
  logic [LAT-1:0] pipe_vld_q;
  logic [31:0]    pipe_exp_q [LAT];
  logic [CW-1:0]  pipe_idx_q [LAT];

  logic          tail_vld;
  logic [31:0]   tail_exp;
  logic [CW-1:0] tail_idx;

  logic [CW-1:0] vec_idx_q, vec_idx_d;
  logic [CW-1:0] pass_q, pass_d;
  logic [CW-1:0] fail_q, fail_d;
  logic [CW-1:0] ffi_q, ffi_d;
  logic [31:0]   ffg_q, ffg_d;
  logic          seen_q, seen_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [3:0]    sel_q, sel_d;

  assign tail_vld = pipe_vld_q[LAT-1];
  assign tail_exp = pipe_exp_q[LAT-1];
  assign tail_idx = pipe_idx_q[LAT-1];

  // Leaving DRAIN once only the tail can still be valid: the tail is compared
  // on this edge, so the pipeline is empty when DONE is entered.
  if (LAT == 1) begin : g_drain_lat1
    assign drain_empty = 1'b1;
  end else begin : g_drain_latn
    assign drain_empty = ~|pipe_vld_q[LAT-2:0];
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
        if (cmd_valid && cmd_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_empty) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xfer = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    vec_idx_d = vec_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ffi_d     = ffi_q;
    ffg_d     = ffg_q;
    seen_d    = seen_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    if (clear) begin
      vec_idx_d = '0;
      pass_d    = '0;
      fail_d    = '0;
      ffi_d     = '1;
      ffg_d     = '0;
      seen_d    = 1'b0;
    end else begin
      if (xfer) begin
        vec_idx_d = vec_idx_q + CW'(1);
        a_d       = cmd_a;
        b_d       = cmd_b;
        sel_d     = cmd_sel;
      end
      if (tail_vld) begin
        if (alu_out == tail_exp) begin
          if (pass_q != '1) pass_d = pass_q + CW'(1);
        end else begin
          if (fail_q != '1) fail_d = fail_q + CW'(1);
          // A separate flag is needed: an all-ones index is a legal vector index.
          if (!seen_q) begin
            seen_d = 1'b1;
            ffi_d  = tail_idx;
            ffg_d  = alu_out;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ffi_q     <= '1;
      ffg_q     <= '0;
      seen_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
    end else begin
      vec_idx_q <= vec_idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ffi_q     <= ffi_d;
      ffg_q     <= ffg_d;
      seen_q    <= seen_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
    end
  end

  // Payload stages need no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= xfer;
      for (int i = 1; i < LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
    pipe_exp_q[0] <= cmd_exp;
    pipe_idx_q[0] <= vec_idx_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_exp_q[i] <= pipe_exp_q[i-1];
      pipe_idx_q[i] <= pipe_idx_q[i-1];
    end
  end

  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_sel        = sel_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_got = ffg_q;

endmodule

// File: tb/tb_alu_stim_checker.sv
// tb/tb_alu_stim_checker.sv - scoreboard bench for alu_stim_checker
module tb_alu_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cmd_valid, cmd_last;
  logic [31:0] cmd_a, cmd_b, cmd_exp;
  logic [3:0]  cmd_sel;

  // Instance 0: LAT=1 CW=16, instance 1: LAT=3 CW=16, instance 2: LAT=1 CW=4
  logic        rdy0, busy0, done0, rdy1, busy1, done1, rdy2, busy2, done2;
  logic [31:0] a0, b0, out0, fg0, a1, b1, out1, fg1, a2, b2, out2, fg2;
  logic [3:0]  s0, s1, s2;
  logic [15:0] pc0, fc0, fi0, pc1, fc1, fi1;
  logic [3:0]  pc2, fc2, fi2;

  alu_stim_checker #(.LAT(1), .CW(16)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_exp(cmd_exp), .cmd_last(cmd_last),
    .alu_a(a0), .alu_b(b0), .alu_sel(s0), .alu_out(out0), .busy(busy0), .done(done0),
    .pass_cnt(pc0), .fail_cnt(fc0), .first_fail_idx(fi0), .first_fail_got(fg0));

  alu_stim_checker #(.LAT(3), .CW(16)) u_l3 (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_exp(cmd_exp), .cmd_last(cmd_last),
    .alu_a(a1), .alu_b(b1), .alu_sel(s1), .alu_out(out1), .busy(busy1), .done(done1),
    .pass_cnt(pc1), .fail_cnt(fc1), .first_fail_idx(fi1), .first_fail_got(fg1));

  alu_stim_checker #(.LAT(1), .CW(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_exp(cmd_exp), .cmd_last(cmd_last),
    .alu_a(a2), .alu_b(b2), .alu_sel(s2), .alu_out(out2), .busy(busy2), .done(done2),
    .pass_cnt(pc2), .fail_cnt(fc2), .first_fail_idx(fi2), .first_fail_got(fg2));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU models: combinational for LAT=1, two extra register stages for LAT=3
  logic [31:0] l3_r1, l3_r2;
  assign out0 = alu_f(a0, b0, s0);
  assign out2 = alu_f(a2, b2, s2);
  always @(posedge clk) begin
    l3_r1 <= alu_f(a1, b1, s1);
    l3_r2 <= l3_r1;
  end
  assign out1 = l3_r2;

  logic        o_busy [3], o_rdy [3], o_done [3];
  logic [31:0] o_pass [3], o_fail [3], o_ffi [3], o_ffg [3], o_a [3], o_sel [3];
  assign o_busy[0] = busy0;  assign o_busy[1] = busy1;  assign o_busy[2] = busy2;
  assign o_rdy[0]  = rdy0;   assign o_rdy[1]  = rdy1;   assign o_rdy[2]  = rdy2;
  assign o_done[0] = done0;  assign o_done[1] = done1;  assign o_done[2] = done2;
  assign o_pass[0] = {16'b0, pc0}; assign o_pass[1] = {16'b0, pc1}; assign o_pass[2] = {28'b0, pc2};
  assign o_fail[0] = {16'b0, fc0}; assign o_fail[1] = {16'b0, fc1}; assign o_fail[2] = {28'b0, fc2};
  assign o_ffi[0]  = {16'b0, fi0}; assign o_ffi[1]  = {16'b0, fi1}; assign o_ffi[2]  = {28'b0, fi2};
  assign o_ffg[0]  = fg0;    assign o_ffg[1]  = fg1;    assign o_ffg[2]  = fg2;
  assign o_a[0]    = a0;     assign o_a[1]    = a1;     assign o_a[2]    = a2;
  assign o_sel[0]  = {28'b0, s0}; assign o_sel[1] = {28'b0, s1}; assign o_sel[2] = {28'b0, s2};

  localparam logic [31:0] NONE [3] = '{32'hFFFF, 32'hFFFF, 32'hF};
  localparam int          LATS [3] = '{1, 3, 1};

  typedef struct packed {
    logic [31:0] pass;
    logic [31:0] fail;
    logic [31:0] ffi;
    logic [31:0] ffg;
  } res_t;

  res_t sb_q [3][$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] p, input logic [31:0] f,
                      input logic [31:0] i, input logic [31:0] g);
    res_t r;
    r.pass = p; r.fail = f; r.ffi = i; r.ffg = g;
    sb_q[k].push_back(r);
  endtask

  // Monitor: on every rising done, pop the expected run result and compare;
  // also measures how many cycles each instance spent in DRAIN.
  int   drain_cnt [3];
  logic done_prev [3];
  res_t mr;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        drain_cnt[k] = 0;
        done_prev[k] = 1'b0;
      end else begin
        if (o_busy[k] && !o_rdy[k]) drain_cnt[k]++;
        if (o_done[k] && !done_prev[k]) begin
          if (sb_q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done inst=%0d", k);
          end else begin
            mr = sb_q[k].pop_front();
            chk($sformatf("pass_cnt[%0d]", k), o_pass[k], mr.pass);
            chk($sformatf("fail_cnt[%0d]", k), o_fail[k], mr.fail);
            chk($sformatf("first_fail_idx[%0d]", k), o_ffi[k], mr.ffi);
            chk($sformatf("first_fail_got[%0d]", k), o_ffg[k], mr.ffg);
            chk($sformatf("drain_cycles[%0d]", k), drain_cnt[k], LATS[k]);
          end
          drain_cnt[k] = 0;
        end
        done_prev[k] = o_done[k];
      end
    end
  end

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_busy[%0d]", tag, k), o_busy[k], 0);
      chk($sformatf("%s_ready[%0d]", tag, k), o_rdy[k], 0);
      chk($sformatf("%s_done[%0d]", tag, k), o_done[k], 0);
      chk($sformatf("%s_pass[%0d]", tag, k), o_pass[k], 0);
      chk($sformatf("%s_fail[%0d]", tag, k), o_fail[k], 0);
      chk($sformatf("%s_ffi[%0d]", tag, k), o_ffi[k], NONE[k]);
      chk($sformatf("%s_ffg[%0d]", tag, k), o_ffg[k], 0);
      chk($sformatf("%s_alu_a[%0d]", tag, k), o_a[k], 0);
      chk($sformatf("%s_alu_sel[%0d]", tag, k), o_sel[k], 0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("start_busy[%0d]", k), o_busy[k], 1);
      chk($sformatf("start_ready[%0d]", k), o_rdy[k], 1);
      chk($sformatf("start_done[%0d]", k), o_done[k], 0);
      chk($sformatf("start_pass[%0d]", k), o_pass[k], 0);
      chk($sformatf("start_fail[%0d]", k), o_fail[k], 0);
      chk($sformatf("start_ffi[%0d]", k), o_ffi[k], NONE[k]);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                      input logic [31:0] e, input logic l);
    for (int k = 0; k < 3; k++) chk($sformatf("send_ready[%0d]", k), o_rdy[k], 1);
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_exp = e; cmd_last = l;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic bubble(input logic st);
    cmd_valid = 1'b0;
    start     = st;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(o_done[0] && o_done[1] && o_done[2]) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=%0d%0d%0d exp=111", o_done[0], o_done[1], o_done[2]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("por");

    // Four matching vectors back to back
    do_start();
    send(32'd5, 32'd3, 4'd0, 32'd8, 1'b0);
    send(32'd10, 32'd4, 4'd1, 32'd6, 1'b0);
    send(32'hF0F0, 32'hFF00, 4'd2, 32'hF000, 1'b0);
    send(32'h1234, 32'h0F00, 4'd3, 32'h1F34, 1'b1);
    for (int k = 0; k < 3; k++) push(k, 4, 0, NONE[k], 0);
    wait_done();

    // Vector 2 expects 2 but ALU gives 3; vector 4 also mismatches later
    do_start();
    send(32'd1, 32'd1, 4'd0, 32'd2, 1'b0);
    send(32'd7, 32'd2, 4'd1, 32'd5, 1'b0);
    send(32'd1, 32'd2, 4'd0, 32'd2, 1'b0);
    send(32'hAA, 32'h55, 4'd4, 32'hFF, 1'b0);
    send(32'd2, 32'd2, 4'd0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) push(k, 3, 2, 2, 3);
    wait_done();

    // Toggling valid, with a start pulse mid-run that must be ignored
    do_start();
    send(32'd3, 32'd4, 4'd0, 32'd7, 1'b0);
    bubble(1'b1);
    send(32'd9, 32'd9, 4'd4, 32'd0, 1'b0);
    bubble(1'b0);
    send(32'd8, 32'd1, 4'd1, 32'd7, 1'b1);
    for (int k = 0; k < 3; k++) push(k, 3, 0, NONE[k], 0);
    wait_done();

    // Reset mid-run after two transfers, asserted together with start
    do_start();
    send(32'd1, 32'd2, 4'd0, 32'd3, 1'b0);
    send(32'd4, 32'd5, 4'd0, 32'd9, 1'b0);
    cmd_valid = 1'b1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    chk_reset("midrun_rst");
    repeat (2) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle_ready[%0d]", k), o_rdy[k], 0);
        chk($sformatf("idle_busy[%0d]", k), o_busy[k], 0);
      end
    end
    cmd_valid = 1'b0;

    // 20 vectors, vector 17 mismatches: saturation and index wrap for CW=4
    do_start();
    for (int i = 0; i < 20; i++)
      send(32'(i), 32'd1, 4'd0, (i == 17) ? 32'd0 : 32'(i + 1), i == 19);
    push(0, 19, 1, 17, 32'h12);
    push(1, 19, 1, 17, 32'h12);
    push(2, 15, 1, 1, 32'h12);
    wait_done();

    // Restart from DONE (checked inside do_start), then finish cleanly
    do_start();
    send(32'd6, 32'd6, 4'd4, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) push(k, 1, 0, NONE[k], 0);
    wait_done();

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("sb_empty[%0d]", k), sb_q[k].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
